// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter sequencer: decoder opcodes and
// the run/halt state of the sequencer FSM.
package pc_pkg;

   typedef enum logic [2:0] {
      OP_NEXT   = 3'd0,
      OP_JUMP   = 3'd1,
      OP_BRANCH = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4,
      OP_HALT   = 3'd5
   } op_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for CALL/RET. Only the pointer is reset; the entry
// storage keeps whatever it held so reset costs no data-path reset fan-out.
module pc_ret_stack #(
   parameter int ADDR_WIDTH  = 11,
   parameter int STACK_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [ADDR_WIDTH-1:0] push_data,
   output logic [ADDR_WIDTH-1:0] top,
   output logic                  empty,
   output logic                  full
);

   localparam int PTR_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      ptr_dec;
   logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];

   assign ptr_dec = ptr - PTR_W'(1);
   assign empty   = (ptr == '0);
   assign full    = (ptr == PTR_W'(STACK_DEPTH));
   assign top     = mem[ptr_dec[IDX_W-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (push && !full) begin
         ptr <= ptr + PTR_W'(1);
      end else if (pop && !empty) begin
         ptr <= ptr_dec;
      end
   end

   // ptr never equals STACK_DEPTH on a write, so the slice stays in range
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[ptr[IDX_W-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-address selection, run/halt FSM, sticky
// stack fault, and the return-address stack for CALL/RET.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 11,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
   parameter int                    STACK_DEPTH = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  En,
   input  logic [2:0]            Op,
   input  logic [ADDR_WIDTH-1:0] Target,
   input  logic [ADDR_WIDTH-1:0] Offset,
   input  logic                  Cond,
   output logic [ADDR_WIDTH-1:0] Addr,
   output logic                  Halted,
   output logic                  StackEmpty,
   output logic                  StackFull,
   output logic                  Fault
);

   state_t                  state;
   state_t                  state_nxt;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [ADDR_WIDTH-1:0]   addr_inc;
   logic [ADDR_WIDTH-1:0]   branch_addr;
   logic signed [ADDR_WIDTH-1:0] addr_s;
   logic signed [ADDR_WIDTH-1:0] offset_s;
   logic signed [ADDR_WIDTH-1:0] branch_s;
   logic [ADDR_WIDTH-1:0]   stack_top;
   logic                    fault_nxt;
   logic                    push;
   logic                    pop;

   assign addr_inc    = Addr + ADDR_WIDTH'(1);
   assign addr_s      = $signed(Addr);
   assign offset_s    = $signed(Offset);
   assign branch_s    = addr_s + offset_s;
   assign branch_addr = $unsigned(branch_s);
   assign Halted      = (state == ST_HALT);

   pc_ret_stack #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (Clk),
      .rst       (Reset),
      .push      (push),
      .pop       (pop),
      .push_data (addr_inc),
      .top       (stack_top),
      .empty     (StackEmpty),
      .full      (StackFull)
   );

   // Stack misuse freezes the PC and parks the FSM instead of corrupting state
   always_comb begin
      addr_nxt  = Addr;
      state_nxt = state;
      fault_nxt = Fault;
      push      = 1'b0;
      pop       = 1'b0;
      if (state == ST_RUN && En) begin
         case (Op)
            OP_JUMP:   addr_nxt = Target;
            OP_BRANCH: addr_nxt = Cond ? branch_addr : addr_inc;
            OP_CALL: begin
               if (StackFull) begin
                  fault_nxt = 1'b1;
                  state_nxt = ST_HALT;
               end else begin
                  push     = 1'b1;
                  addr_nxt = Target;
               end
            end
            OP_RET: begin
               if (StackEmpty) begin
                  fault_nxt = 1'b1;
                  state_nxt = ST_HALT;
               end else begin
                  pop      = 1'b1;
                  addr_nxt = stack_top;
               end
            end
            OP_HALT:   state_nxt = ST_HALT;
            default:   addr_nxt = addr_inc;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= ST_RUN;
         Addr  <= RESET_ADDR;
         Fault <= 1'b0;
      end else begin
         state <= state_nxt;
         Addr  <= addr_nxt;
         Fault <= fault_nxt;
      end
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the BIP processor family, replacing the fixed 11-bit free-running PC. It generates the instruction-memory address each cycle. It supports stall, absolute jump, conditional relative branch, call/return through an internal return-address stack, and halt. It sits between the instruction decoder, which drives `Op`, `Target`, `Offset` and `Cond`, and the program memory address port.

## Interface
- `ADDR_WIDTH`, 11, width of `Addr`, `Target`, `Offset`
- `RESET_ADDR`, 0, value loaded into `Addr` on reset
- `STACK_DEPTH`, 4, return-stack entries (≥1)
- `Clk`  in  1  single clock; all state updates on rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `En`  in  1  1 = execute `Op` this edge; 0 = stall (all state holds)
- `Op`  in  3  operation: NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4, HALT=5; 6–7 behave as NEXT
- `Target`  in  ADDR_WIDTH  absolute destination for JUMP/CALL
- `Offset`  in  ADDR_WIDTH  two's-complement displacement for BRANCH
- `Cond`  in  1  BRANCH taken when 1
- `Addr`  out  ADDR_WIDTH  current fetch address (registered)
- `Halted`  out  1  1 while in HALT state
- `StackEmpty`  out  1  return stack holds 0 entries
- `StackFull`  out  1  return stack holds STACK_DEPTH entries
- `Fault`  out  1  sticky: stack overflow or underflow occurred

## Operation
- Two states: RUN and HALT. Reset enters RUN.
- In RUN with `En`=1, per `Op`:
  - NEXT: `Addr` ← `Addr`+1
  - JUMP: `Addr` ← `Target`
  - BRANCH: `Addr` ← `Addr`+`Offset` if `Cond`, else `Addr`+1
  - CALL: push `Addr`+1; `Addr` ← `Target`
  - RET: pop; `Addr` ← popped value
  - HALT: `Addr` holds; go to HALT
- CALL while `StackFull`: no push, `Addr` holds, `Fault`←1, go to HALT.
- RET while `StackEmpty`: no pop, `Addr` holds, `Fault`←1, go to HALT.
- HALT state: `Addr`, the stack and `Fault` all hold. All `Op`/`En` are ignored. Only `Reset` exits.
- `En`=0: nothing changes, in either state.
- Arithmetic is modulo 2^ADDR_WIDTH. Increment from all-ones wraps to 0. Branch sum truncates to ADDR_WIDTH. Pushed `Addr`+1 also wraps.
- The stack is a LIFO with a pointer 0..STACK_DEPTH. `StackEmpty` = (ptr==0). `StackFull` = (ptr==STACK_DEPTH).
- Stack contents are not cleared by reset; only the pointer is reset.

## Timing
- Reset values, asynchronous on `Reset` rising:
  - `Addr`=RESET_ADDR, `Halted`=0, `StackEmpty`=1, `StackFull`=0, `Fault`=0
  - stack pointer = 0, state = RUN
- Reset mid-operation: takes effect immediately, regardless of `En`/`Op`. The first edge after `Reset` deasserts executes that cycle's `Op` normally.
- Latency: inputs are sampled at edge N; `Addr`, the flags and `Halted` reflect the result after edge N (one-cycle registered).
- No combinational path from any input to any output.
- `Halted` and `Fault` assert in the same cycle `Addr` would otherwise have changed.

## Structure
- Package `pc_pkg`: `Op` encodings (OP_NEXT…OP_HALT) and state encoding (ST_RUN, ST_HALT).
- Sub-module `pc_ret_stack`:
  - parameters ADDR_WIDTH and STACK_DEPTH
  - inputs: push, pop, push data
  - outputs: top, empty, full
  - asynchronous reset of the pointer only
- The top level holds the state machine, next-address mux and sticky `Fault`.

## Test plan
- Reset and count: `Reset` 1 for 150 ns, then NEXT with `En`=1 for 5 cycles → `Addr` = 0,1,2,3,4,5. Mid-run `En`=0 for 2 cycles → `Addr` holds.
- Wrap and branch (ADDR_WIDTH=11):
  - `Addr`=0x7FF, NEXT → 0x000
  - at 0x010, BRANCH `Offset`=0x7FC `Cond`=1 → 0x00C
  - `Cond`=0 → 0x011
- Call/return: at 0x020, CALL `Target`=0x100 → `Addr`=0x100 and `StackEmpty`=0. Then RET → `Addr`=0x021 and `StackEmpty`=1.
- Overflow: 4 CALLs (STACK_DEPTH=4) → `StackFull`=1. A 5th CALL → `Addr` unchanged, `Fault`=1, `Halted`=1. Subsequent JUMPs are ignored.
- Underflow: RET with an empty stack → `Fault`=1, `Halted`=1, `Addr` unchanged.
- HALT and mid-halt reset:
  - HALT op → `Halted`=1, `Addr` frozen
  - asserting `Reset` asynchronously between edges → `Addr`=RESET_ADDR, `Halted`=0, `Fault`=0 immediately
